fft_spi_in: RTL and testbench
=============================

Name: fft_spi_in

Overview:
- SPI slave receiver. It is the far end of the FFT result link driven by fft_spi_out.
- Accepts a frame of N words of W bits on sclk/mosi/cs and rebuilds the parallel data_bus in the clk domain.
- Used on the receive board, and on-chip as a loopback checker for fft_spi_out.
- SPI mode 0: sample on sclk rising edge, cs active-low, each word MSB first, word 0 first.

Parameters:
N, 8, words per frame
W, 16, bits per word

Ports:
clk  input  1  system clock (16 MHz)
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master, asynchronous to clk
mosi  input  1  SPI data from master, asynchronous to clk
cs  input  1  SPI chip select, active-low, asynchronous to clk
data_bus  output  N*W  last good frame; word k at bits [k*W+W-1 : k*W]
data_valid  output  1  one-clk pulse when data_bus is updated
busy  output  1  high while a frame is in progress (cs low)
frame_err  output  1  one-clk pulse on a short or overlong frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_bus = 0; data_valid, busy, frame_err = 0.
  - State IDLE; shift register and counters cleared.
- Synchronisers and edge detect:
  - sclk, mosi and cs each pass through a 2-FF synchroniser.
  - cs sync resets to 1; sclk and mosi sync reset to 0.
  - Rise/fall detect compares the sync output with one further register.
- Timing constraint:
  - f_sclk ≤ f_clk/4.
  - cs falling edge to first sclk rise ≥ 2 clk.
- Sampling: on each detected sclk rise, mosi_sync shifts into the shift register LSB (shift left).
- Bit counter width clog2(W); word counter width clog2(N+1).
- States:
  - IDLE: on cs fall → SHIFT; clear counters; busy=1.
  - SHIFT:
    - On sclk rise, shift one bit.
    - When bit W-1 is captured, write the word into the staging buffer slot word_cnt, then increment word_cnt.
    - When word N-1 completes, the next clk copies staging to data_bus, pulses data_valid, and goes to DONE.
  - DONE:
    - Further sclk rises set the overrun flag; no data change.
    - On cs rise: → IDLE, busy=0, frame_err pulses if overrun is set.
  - SHIFT on cs rise before the frame completes: → IDLE, busy=0, frame_err pulses, data_bus unchanged (partial frame discarded).
- Latency: data_valid rises 4 clk after the physical sclk edge that carries the final bit (2 sync + 1 detect + 1 commit).
- Only complete frames update data_bus. Staging is separate, so data_bus stays stable during reception.
- cs rising and an sclk rise in the same clk: cs wins, and the bit is discarded.
- Reset mid-frame: immediate return to reset state. The following frame is received normally once cs has been seen high.
- cs low at reset release: the block stays IDLE until a cs high→low transition is seen.

Optional Feature:
- Macro SPI_IN_WORD_STROBE_EN.
- Defined: adds output word_data [W-1:0] and output word_valid [1].
  - word_valid pulses one clk as each word completes, including in partial frames.
  - word_data holds the word until the next strobe.
  - word_data resets to 0.
- Undefined: ports and logic are absent; the frame interface is unchanged.

Decomposition:
- Shared package fft_spi_pkg:
  - Defaults FFT_N=8 and FFT_W=16.
  - State encoding (IDLE, SHIFT, DONE).
  - SPI mode constant.
  - The package is also imported by fft_spi_out.
- One sub-module, spi_sync_edge: 2-FF synchroniser plus rise/fall detect, parameterised reset value.
  - Instantiated for sclk and cs.
  - mosi uses the synchroniser only.

Test Plan:
- Frame 0x0001,0x0002,...,0x0008 at sclk=clk/4 → data_bus=128'h00080007000600050004000300020001; one data_valid pulse, 4 clk after last sclk rise; busy falls 2-3 clk after cs rise.
- cs rises after 3 words (48 bits) → frame_err pulse; no data_valid; data_bus keeps the previous frame.
- Full frame plus 5 extra sclk cycles → data_valid after bit 128; frame_err at cs rise; data_bus equals the 128-bit frame.
- rst_n low for 1 clk mid-word 4 → outputs 0 immediately; the next full frame 0xFFFF×8 is received correctly.
- Back-to-back frames A then B, with cs high for 3 clk between them → two data_valid pulses, data_bus = A then B, no frame_err.
- With SPI_IN_WORD_STROBE_EN: frame 0x1234,0xABCD,... → word_valid ×8 with word_data=0x1234, then 0xABCD, ... in order; a partial frame still strobes the completed words.

Source files
------------

// File: rtl/fft_spi_pkg.sv
// fft_spi_pkg: frame geometry defaults, SPI mode and receiver state encoding
// shared by fft_spi_in and fft_spi_out.
package fft_spi_pkg;
    localparam int FFT_N    = 8;
    localparam int FFT_W    = 16;
    localparam int SPI_MODE = 0;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser for an asynchronous input plus one extra
// register for rise/fall detection; RST_VAL sets the value all stages reset to.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {meta_q, sync_q, prev_q} <= {3{RST_VAL}};
        else        {meta_q, sync_q, prev_q} <= {d_i, meta_q, sync_q};
    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/fft_spi_in.sv
// fft_spi_in: SPI mode-0 slave that rebuilds an N x W frame into data_bus.
// Optional per-word strobe outputs under `define SPI_IN_WORD_STROBE_EN.
module fft_spi_in
    import fft_spi_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sclk,
    input  logic           mosi,
    input  logic           cs,
    output logic [N*W-1:0] data_bus,
    output logic           data_valid,
    output logic           busy,
    output logic           frame_err
`ifdef SPI_IN_WORD_STROBE_EN
    ,
    output logic [W-1:0]   word_data,
    output logic           word_valid
`endif
);
    localparam int BW = $clog2(W);
    localparam int CW = $clog2(N+1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W-1);
    localparam logic [CW-1:0] WORD_END = CW'(N);

    logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_m_q, mosi_q;
    logic word_done;
    logic [W-1:0] word;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d_i(cs),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {mosi_m_q, mosi_q} <= 2'b00;
        else        {mosi_m_q, mosi_q} <= {mosi, mosi_m_q};

    spi_state_e     state_q;
    logic [W-1:0]   shift_q;
    logic [BW-1:0]  bit_cnt_q;
    logic [CW-1:0]  word_cnt_q;
    logic [N*W-1:0] stage_q, data_bus_q;
    logic           data_valid_q, busy_q, frame_err_q, overrun_q;
    logic [1:0]     ready_q;
    logic           armed_q;

    assign word      = {shift_q[W-2:0], mosi_q};
    assign word_done = (state_q == SHIFT) && (word_cnt_q != WORD_END) && !cs_rise
                       && sclk_rise && (bit_cnt_q == BIT_LAST);

    // armed_q blocks a frame start until cs has really been seen high after reset,
    // since the cs synchroniser resets to 1 and would otherwise fake a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            stage_q      <= '0;
            data_bus_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            ready_q      <= 2'b00;
            armed_q      <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ready_q      <= {ready_q[0], 1'b1};
            if (ready_q[1] && cs_sync) armed_q <= 1'b1;
            case (state_q)
                IDLE: if (cs_fall && armed_q) begin
                    state_q    <= SHIFT;
                    bit_cnt_q  <= '0;
                    word_cnt_q <= '0;
                    overrun_q  <= 1'b0;
                    busy_q     <= 1'b1;
                end
                SHIFT: if (word_cnt_q == WORD_END) begin
                    data_bus_q   <= stage_q;
                    data_valid_q <= 1'b1;
                    overrun_q    <= sclk_rise && !cs_rise;
                    busy_q       <= !cs_rise;
                    state_q      <= cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    frame_err_q <= 1'b1;
                end else if (sclk_rise) begin
                    shift_q   <= word;
                    bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
                    if (word_done) begin
                        stage_q[int'(word_cnt_q)*W +: W] <= word;
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end
                DONE: if (cs_rise) begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    frame_err_q <= overrun_q;
                end else if (sclk_rise) begin
                    overrun_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_bus   = data_bus_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

`ifdef SPI_IN_WORD_STROBE_EN
    logic [W-1:0] word_data_q;
    logic         word_valid_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= word_done;
            if (word_done) word_data_q <= word;
        end
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
`endif
endmodule

// File: tb/tb_fft_spi_in.sv
// tb_fft_spi_in: directed and randomized SPI frames against a frame-level model.
module tb_fft_spi_in;
    localparam int N = 8;
    localparam int W = 16;
    localparam int FB = N*W;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0, cs = 1'b1;
    logic [FB-1:0] data_bus;
    logic data_valid, busy, frame_err;
`ifdef SPI_IN_WORD_STROBE_EN
    logic [W-1:0] word_data;
    logic word_valid;
`endif

    fft_spi_in #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs(cs),
        .data_bus(data_bus), .data_valid(data_valid), .busy(busy), .frame_err(frame_err)
`ifdef SPI_IN_WORD_STROBE_EN
        , .word_data(word_data), .word_valid(word_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int dv_cnt = 0, err_cnt = 0;
    time dv_t = 0, bf_t = 0, cs_t = 0, rise_t = 0;
    logic busy_d = 1'b0;
    logic [W-1:0] tx_words [N];
    logic [W-1:0] wq [$];
    logic [FB-1:0] exp_bus = '0;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            if (dv_cnt == 1) dv_t = $time;
        end
        if (frame_err) err_cnt++;
        if (busy_d && !busy && bf_t == 0) bf_t = $time;
        busy_d = busy;
`ifdef SPI_IN_WORD_STROBE_EN
        if (word_valid) wq.push_back(word_data);
`endif
    end

    task automatic chk(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one frame of nbits (bits past N*W are random); rst_at >= 0 pulses
    // rst_n before that bit's rising edge and abandons the frame.
    task automatic run_frame(input int nbits, input int gap, input int rst_at);
        logic [FB-1:0] prev;
        bit aborted;
        int eff, nw, exp_dv, exp_err;
        aborted = 0;
        prev = exp_bus;
        @(negedge clk);
        dv_cnt = 0; err_cnt = 0; wq.delete();
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            mosi = (i < FB) ? tx_words[i/W][W-1-(i%W)] : 1'($urandom);
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_data_bus", data_bus, '0);
                chk("rst_busy", {127'b0, busy}, '0);
                chk("rst_valid", {127'b0, data_valid}, '0);
                @(negedge clk) rst_n = 1'b1;
                aborted = 1;
                break;
            end
            @(negedge clk);
            @(negedge clk);
            sclk = 1'b1;
            if (i == FB-1) rise_t = $time;
            @(negedge clk);
            if (i == nbits/2) begin
                chk("mid_busy", {127'b0, busy}, 1);
                chk("mid_stable", data_bus, prev);
            end
        end
        @(negedge clk) sclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cs = 1'b1;
        cs_t = $time;
        bf_t = 0;
        repeat (gap) @(negedge clk);
        eff = aborted ? rst_at : (nbits < FB ? nbits : FB);
        if (aborted) begin
            exp_bus = '0; exp_dv = 0; exp_err = 0;
        end else if (nbits >= FB) begin
            for (int k = 0; k < N; k++) exp_bus[k*W +: W] = tx_words[k];
            exp_dv = 1; exp_err = (nbits > FB) ? 1 : 0;
        end else begin
            exp_dv = 0; exp_err = 1;
        end
        chk("dv_count", FB'(dv_cnt), FB'(exp_dv));
        chk("data_bus", data_bus, exp_bus);
        if (exp_dv == 1) chk("dv_latency", FB'(dv_t - rise_t), FB'(40));
        if (gap >= 4) begin
            chk("err_count", FB'(err_cnt), FB'(exp_err));
            if (!aborted) chk("busy_fall", FB'((bf_t - cs_t) >= 20 && (bf_t - cs_t) <= 30), 1);
        end
`ifdef SPI_IN_WORD_STROBE_EN
        nw = eff / W;
        chk("strobe_count", FB'(wq.size()), FB'(nw));
        for (int k = 0; k < nw && k < wq.size(); k++) chk("strobe_word", FB'(wq[k]), FB'(tx_words[k]));
`else
        nw = eff;
`endif
    endtask

    task automatic rand_words();
        for (int k = 0; k < N; k++) tx_words[k] = W'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_data_bus", data_bus, '0);
        chk("reset_valid", {127'b0, data_valid}, '0);
        chk("reset_busy", {127'b0, busy}, '0);
        chk("reset_err", {127'b0, frame_err}, '0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int k = 0; k < N; k++) tx_words[k] = W'(k + 1);
        run_frame(FB, 8, -1);
        chk("frame_1_to_8", data_bus, 128'h00080007000600050004000300020001);

        rand_words();
        run_frame(3*W, 8, -1);

        rand_words();
        run_frame(FB + 5, 8, -1);

        rand_words();
        run_frame(FB, 8, 3*W + 7);

        for (int k = 0; k < N; k++) tx_words[k] = 16'hFFFF;
        run_frame(FB, 8, -1);

        tx_words = '{16'h1234, 16'hABCD, 16'h5A5A, 16'hC3C3, 16'h0F0F, 16'h8001, 16'h7FFE, 16'hDEAD};
        run_frame(FB, 2, -1);
        rand_words();
        run_frame(FB, 8, -1);

        for (int r = 0; r < 10; r++) begin
            int sel, nb;
            rand_words();
            sel = $urandom_range(2, 0);
            nb = (sel == 0) ? FB : (sel == 1) ? $urandom_range(FB-1, 0) : FB + $urandom_range(6, 1);
            run_frame(nb, 8, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
